// File: rtl/bldc_main_pkg.sv
// Shared constants, types and the commutation table for the BLDC gate-drive controller.
// Phase vectors are one-hot {C,B,A}; a drive word carries high-side and low-side vectors.
package bldc_main_pkg;

    localparam int PWM_W     = 4;
    localparam int DEAD_TIME = 4;
    localparam int DEAD_W    = $clog2(DEAD_TIME);

    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    // Hall code -> step, named high-side phase first, low-side phase second.
    localparam logic [2:0] H_AB = 3'b001;
    localparam logic [2:0] H_AC = 3'b101;
    localparam logic [2:0] H_BC = 3'b100;
    localparam logic [2:0] H_BA = 3'b110;
    localparam logic [2:0] H_CA = 3'b010;
    localparam logic [2:0] H_CB = 3'b011;

    localparam logic [2:0] PH_A = 3'b001;
    localparam logic [2:0] PH_B = 3'b010;
    localparam logic [2:0] PH_C = 3'b100;

    typedef enum logic {
        ST_RUN,
        ST_DEAD
    } dt_state_e;

    typedef struct packed {
        logic [2:0] hi;
        logic [2:0] lo;
    } drive_t;

    // High side and low side always name different phases, so no decoded
    // step can short a leg. Fault codes 000/111 fall to the all-off default.
    function automatic drive_t decode_step(input logic [2:0] h, input logic pwm);
        drive_t d;
        d = '0;
        case (h)
            H_AB:    begin d.hi = PH_A; d.lo = PH_B; end
            H_AC:    begin d.hi = PH_A; d.lo = PH_C; end
            H_BC:    begin d.hi = PH_B; d.lo = PH_C; end
            H_BA:    begin d.hi = PH_B; d.lo = PH_A; end
            H_CA:    begin d.hi = PH_C; d.lo = PH_A; end
            H_CB:    begin d.hi = PH_C; d.lo = PH_B; end
            default: d = '0;
        endcase
        if (!pwm) begin
            d.hi = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/bldc_main_pwm_gen.sv
// Free-running 16-clock PWM: counter, period-aligned duty register and comparator.
// The duty register only reloads on the 15->0 wrap, so a period never mixes two duties.
module pwm_gen
    import bldc_main_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [PWM_W-1:0] i_duty,
    output logic             o_pwm
);

    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] r_duty;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_duty <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_MAX) begin
                r_duty <= i_duty;
            end
        end
    end

    assign o_pwm = (r_cnt < r_duty);

endmodule

// File: rtl/bldc_main.sv
// Six-step BLDC commutation: Hall synchronizers, step decode, dead-time blanking
// on every step change, and registered gate drives. PWM comes from pwm_gen.
module bldc_main
    import bldc_main_pkg::*;
(
    input  logic CLK,
    input  logic LOW,
    input  logic H1,
    input  logic H2,
    input  logic H3,
    input  logic D3,
    input  logic D2,
    input  logic D1,
    input  logic D0,
    output logic A_OUT,
    output logic B_OUT,
    output logic C_OUT,
    output logic AA_OUT,
    output logic BB_OUT,
    output logic CC_OUT
);

    logic [2:0]        w_h_raw;
    logic [PWM_W-1:0]  w_duty;
    logic              w_pwm;
    logic              w_change;

    logic [2:0]        r_h_meta;
    logic [2:0]        r_h_sync;
    logic [2:0]        r_h_prev;

    dt_state_e         r_state;
    dt_state_e         w_state_nxt;
    logic [DEAD_W-1:0] r_dead;
    logic [DEAD_W-1:0] w_dead_nxt;
    drive_t            r_drive;
    drive_t            w_drive_nxt;

    assign w_h_raw = {H3, H2, H1};
    assign w_duty  = {D3, D2, D1, D0};

    pwm_gen u_pwm_gen (
        .i_clk  (CLK),
        .i_rst  (LOW),
        .i_duty (w_duty),
        .o_pwm  (w_pwm)
    );

    // r_h_prev resets to the 000 fault code, so the first valid code after
    // reset counts as a change and is blanked like any other step change.
    always_ff @(posedge CLK or posedge LOW) begin
        if (LOW) begin
            r_h_meta <= '0;
            r_h_sync <= '0;
            r_h_prev <= '0;
        end else begin
            r_h_meta <= w_h_raw;
            r_h_sync <= r_h_meta;
            r_h_prev <= r_h_sync;
        end
    end

    assign w_change = (r_h_sync != r_h_prev);

    always_ff @(posedge CLK or posedge LOW) begin
        if (LOW) begin
            r_state <= ST_RUN;
            r_dead  <= '0;
            r_drive <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dead  <= w_dead_nxt;
            r_drive <= w_drive_nxt;
        end
    end

    // A change in RUN blanks the next output and arms three more blank
    // cycles in DEAD; any further change re-arms, restarting the interval.
    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned (no latch).
        w_state_nxt = r_state;
        w_dead_nxt  = r_dead;
        w_drive_nxt = '0;
        case (r_state)
            ST_RUN: begin
                if (w_change) begin
                    w_state_nxt = ST_DEAD;
                    w_dead_nxt  = DEAD_W'(DEAD_TIME - 1);
                end else begin
                    w_drive_nxt = decode_step(r_h_sync, w_pwm);
                end
            end
            ST_DEAD: begin
                if (w_change) begin
                    w_dead_nxt = DEAD_W'(DEAD_TIME - 1);
                end else if (r_dead == '0) begin
                    w_state_nxt = ST_RUN;
                    w_drive_nxt = decode_step(r_h_sync, w_pwm);
                end else begin
                    w_dead_nxt = r_dead - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_dead_nxt  = '0;
            end
        endcase
    end

    assign A_OUT  = r_drive.hi[0];
    assign B_OUT  = r_drive.hi[1];
    assign C_OUT  = r_drive.hi[2];
    assign AA_OUT = r_drive.lo[0];
    assign BB_OUT = r_drive.lo[1];
    assign CC_OUT = r_drive.lo[2];

endmodule

// File: tb/tb_bldc_main.sv
// Scoreboard bench for bldc_main: stimulus queues per-cycle expected drives,
// a negedge monitor pops and compares them; a watcher flags same-phase overlap.
module tb_bldc_main;

    logic CLK = 1'b0;
    logic LOW = 1'b1;
    logic H1 = 1'b0, H2 = 1'b0, H3 = 1'b0;
    logic D3 = 1'b0, D2 = 1'b0, D1 = 1'b0, D0 = 1'b0;
    logic A_OUT, B_OUT, C_OUT, AA_OUT, BB_OUT, CC_OUT;

    always #10 CLK = ~CLK;

    bldc_main dut (
        .CLK    (CLK),
        .LOW    (LOW),
        .H1     (H1),
        .H2     (H2),
        .H3     (H3),
        .D3     (D3),
        .D2     (D2),
        .D1     (D1),
        .D0     (D0),
        .A_OUT  (A_OUT),
        .B_OUT  (B_OUT),
        .C_OUT  (C_OUT),
        .AA_OUT (AA_OUT),
        .BB_OUT (BB_OUT),
        .CC_OUT (CC_OUT)
    );

    typedef struct {
        int         t;
        logic [5:0] exp;
        string      lbl;
    } exp_t;

    typedef struct {
        int         t;
        logic [3:0] v;
    } dchg_t;

    exp_t       sb_q[$];
    dchg_t      d_hist[$];
    int         total = 0;
    int         bad   = 0;
    int         tick  = 0;
    int         base  = 0;
    logic [2:0] h_drv = 3'b000;

    // Output word as {C,B,A high, CC,BB,AA low}.
    logic [5:0] obs;
    exp_t       cur;

    always @(posedge CLK) tick = tick + 1;

    // Commutation table: returns {hi[C,B,A], lo[CC,BB,AA]}.
    function automatic logic [5:0] step_exp(input logic [2:0] h, input bit pwm);
        logic [2:0] hi;
        logic [2:0] lo;
        case (h)
            3'b001:  begin hi = 3'b001; lo = 3'b010; end
            3'b101:  begin hi = 3'b001; lo = 3'b100; end
            3'b100:  begin hi = 3'b010; lo = 3'b100; end
            3'b110:  begin hi = 3'b010; lo = 3'b001; end
            3'b010:  begin hi = 3'b100; lo = 3'b001; end
            3'b011:  begin hi = 3'b100; lo = 3'b010; end
            default: begin hi = 3'b000; lo = 3'b000; end
        endcase
        if (!pwm) hi = 3'b000;
        return {hi, lo};
    endfunction

    // Duty in effect during cycle t: 0 for the first period after reset,
    // then the D present at the most recent wrap edge.
    function automatic logic [3:0] duty_in_cycle(input int t);
        int s;
        int e;
        logic [3:0] v;
        s = t - base;
        if (s < 16) return 4'd0;
        e = base + 16 * (s / 16);
        v = 4'd0;
        foreach (d_hist[i]) if (d_hist[i].t < e) v = d_hist[i].v;
        return v;
    endfunction

    function automatic bit pwm_in_cycle(input int t);
        int s;
        s = t - base;
        if (s < 0) return 1'b0;
        return (32'(s % 16) < 32'(duty_in_cycle(t)));
    endfunction

    // Output seen in cycle t is registered from the pwm of cycle t-1.
    function automatic logic [5:0] exp_at(input int t, input logic [2:0] h);
        return step_exp(h, pwm_in_cycle(t - 1));
    endfunction

    task automatic push(input int t, input logic [5:0] e, input string lbl);
        exp_t x;
        x.t = t; x.exp = e; x.lbl = lbl;
        sb_q.push_back(x);
    endtask

    task automatic push_step(input int from, input int to, input logic [2:0] h, input string lbl);
        for (int t = from; t <= to; t++) push(t, exp_at(t, h), lbl);
    endtask

    task automatic push_zero(input int from, input int to, input string lbl);
        for (int t = from; t <= to; t++) push(t, 6'b000000, lbl);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_h(input logic [2:0] h);
        {H3, H2, H1} = h;
        h_drv = h;
    endtask

    task automatic set_d(input logic [3:0] d);
        dchg_t x;
        {D3, D2, D1, D0} = d;
        x.t = tick; x.v = d;
        d_hist.push_back(x);
    endtask

    // Hall change at cycle c: old step through c+2, blank c+3..c+6, new step from c+7.
    task automatic apply_h(input logic [2:0] h, input int hold, input string lbl);
        int c;
        c = tick;
        push_step(c + 1, c + 2, h_drv, {lbl, "_old"});
        push_zero(c + 3, c + 6, {lbl, "_dead"});
        set_h(h);
        push_step(c + 7, c + hold, h, lbl);
        wait_cyc(hold);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            obs = {C_OUT, B_OUT, A_OUT, CC_OUT, BB_OUT, AA_OUT};
            while (sb_q.size() > 0 && sb_q[0].t <= tick) begin
                cur = sb_q.pop_front();
                total++;
                if (cur.t < tick) begin
                    bad++;
                    $display("FAIL %s: cycle %0d expectation not compared in its cycle (now %0d)",
                             cur.lbl, cur.t, tick);
                end else if (obs !== cur.exp) begin
                    bad++;
                    $display("FAIL %s: cycle %0d got hi(CBA)=%b lo(CBA)=%b, required hi=%b lo=%b",
                             cur.lbl, cur.t, obs[5:3], obs[2:0], cur.exp[5:3], cur.exp[2:0]);
                end
            end
        end
    end

    always @(A_OUT or AA_OUT or B_OUT or BB_OUT or C_OUT or CC_OUT) begin
        total++;
        if ((A_OUT && AA_OUT) || (B_OUT && BB_OUT) || (C_OUT && CC_OUT)) begin
            bad++;
            $display("FAIL overlap: t=%0t A/AA=%b%b B/BB=%b%b C/CC=%b%b, required no same-phase pair",
                     $time, A_OUT, AA_OUT, B_OUT, BB_OUT, C_OUT, CC_OUT);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation reached time limit, required completion");
        $fatal(1);
    end

    initial begin
        int r;
        int c;
        set_h(3'b000);
        set_d(4'd0);
        LOW = 1'b1;
        wait_cyc(1);
        push_zero(tick + 1, tick + 3, "reset");
        wait_cyc(3);
        LOW  = 1'b0;
        base = tick;

        // Rotation with zero duty: high sides stay off, low side follows table.
        apply_h(3'b001, 50, "rot_ab");
        apply_h(3'b101, 50, "rot_ac");
        apply_h(3'b100, 50, "rot_bc");
        apply_h(3'b110, 50, "rot_ba");
        apply_h(3'b010, 50, "rot_ca");
        apply_h(3'b011, 50, "rot_cb");

        // Half duty on step A/B, then the A/B -> A/C transition.
        set_d(4'd8);
        apply_h(3'b001, 80, "d8_ab");
        apply_h(3'b101, 60, "ab_to_ac");

        // Fault codes blank everything until a valid code returns.
        apply_h(3'b111, 30, "fault7");
        apply_h(3'b101, 30, "recover7");
        apply_h(3'b000, 30, "fault0");
        apply_h(3'b100, 30, "recover0");

        // Second change two cycles into dead time restarts the blanking.
        c = tick;
        push_step(c + 1, c + 2, h_drv, "restart_old");
        set_h(3'b110);
        wait_cyc(2);
        set_h(3'b010);
        push_zero(c + 3, c + 8, "restart_dead");
        push_step(c + 9, c + 40, 3'b010, "restart_new");
        wait_cyc(38);

        // Duty 4 -> 12 mid-period: old duty holds until the next wrap.
        set_d(4'd4);
        push_step(tick + 1, tick + 40, h_drv, "d4");
        wait_cyc(40);
        while (((tick - base) % 16) != 7) wait_cyc(1);
        set_d(4'd12);
        push_step(tick + 1, tick + 48, h_drv, "d4_to_12");
        wait_cyc(48);

        set_d(4'd15);
        push_step(tick + 1, tick + 40, h_drv, "d15");
        wait_cyc(40);

        // Reset pulse shortly after a rising edge: outputs must clear before the next edge.
        @(posedge CLK);
        #2;
        LOW = 1'b1;
        r = tick;
        push_zero(r, r + 2, "rst_async");
        wait_cyc(3);
        LOW  = 1'b0;
        base = tick;
        c    = tick;
        push_zero(c + 1, c + 6, "rst_dead");
        push_step(c + 7, c + 60, h_drv, "rst_resume");
        wait_cyc(60);

        wait_cyc(1);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left in queue, required 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bldc_main.md
BLDC_MAIN -- requirements
Module: bldc_main

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock, rising-edge active, nominal 50 MHz.
REQ-002 SHALL have port LOW, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have ports H1, H2, H3, inputs, 1 bit each: raw Hall sensor levels, asynchronous to CLK.
REQ-004 SHALL have ports D3, D2, D1, D0, inputs, 1 bit each: 4-bit PWM duty, D = {D3,D2,D1,D0}, D3 is MSB.
REQ-005 SHALL have ports A_OUT, B_OUT, C_OUT, outputs, 1 bit each: phase A/B/C high-side gate drives, active-high.
REQ-006 SHALL have ports AA_OUT, BB_OUT, CC_OUT, outputs, 1 bit each: phase A/B/C low-side gate drives, active-high.

Function
REQ-007 SHALL pass each Hall input through a 2-flop synchronizer; H = {H3s,H2s,H1s} is the synchronized code.
REQ-008 SHALL run a free-running 4-bit PWM counter, 0..15, wrapping 15->0, for a period of 16 clocks.
REQ-009 SHALL latch D into a duty register only when the counter wraps to 0, giving glitch-free duty changes.
REQ-010 SHALL compute pwm = (counter < duty); duty 0 gives constant 0, and duty 15 gives 15/16 high.
REQ-011 SHALL commutate per H, as H-code -> high-side phase (PWM-gated) / low-side phase (static on):
 - 001 -> A / B
 - 101 -> A / C
 - 100 -> B / C
 - 110 -> B / A
 - 010 -> C / A
 - 011 -> C / B
REQ-012 SHALL treat H = 000 or 111 as a fault step, with all six outputs 0 for as long as the code persists.
REQ-013 SHALL drive every output not named for the current step to 0.
REQ-014 SHALL, when H changes to a different step, force all six outputs to 0 for 4 clocks of dead time, then apply the new step.
REQ-015 SHALL restart the 4-clock dead time from 0 if H changes again during dead time, and then apply the latest step.
REQ-016 SHALL never assert the high-side and low-side outputs of the same phase at once, in any cycle, including around reset and fault steps.
REQ-017 SHALL register all outputs, with no combinational path from any input to any output.
REQ-018 SHALL reach the output within 3 clocks of a Hall edge when no dead time applies: 2 synchronizer cycles plus the output register.
REQ-019 SHALL keep the counter and pwm running independently of Hall activity.

Reset
REQ-020 SHALL, while LOW=1, immediately hold all outputs at 0, with the synchronizers, counter, duty register and dead-time counter all at 0.
REQ-021 SHALL treat the first valid H after LOW deasserts as a step change, so it incurs the 4-clock dead time.
REQ-022 SHALL, if LOW asserts mid-operation (including during dead time), zero all outputs asynchronously with no partial commutation.

Structure
REQ-023 SHALL place the following constants in a shared package: PWM width 4, dead time 4, and the six H-code/step encodings.
REQ-024 SHALL implement the PWM generator (counter, duty register, comparator) as one sub-module, pwm_gen; synchronizers, commutation decode and dead-time logic live in bldc_main.

Verification
REQ-025 SHALL cover: D=0 with the Hall rotation 001,101,100,110,010,011 at 1000 ns per step -> A/B/C_OUT always 0; low side follows the table (BB, CC, CC, AA, AA, BB).
REQ-026 SHALL cover: D=8, H=001 steady -> A_OUT high 8 of every 16 clocks; BB_OUT constantly 1; all other outputs 0.
REQ-027 SHALL cover: H steps 001->101 -> all outputs 0 for exactly 4 clocks after the synchronized change; then A_OUT PWM with CC_OUT=1.
REQ-028 SHALL cover: H=111 or 000 applied -> all outputs 0 within 3 clocks, held until a valid code returns.
REQ-029 SHALL cover: D changed from 4 to 12 mid-period -> the new duty takes effect only from the next counter wrap to 0.
REQ-030 SHALL cover: LOW pulsed high mid-step -> all outputs 0 asynchronously; on release, 4-clock dead time, then the table step resumes; no same-phase high/low overlap at any time.
